// File: rtl/top_level_pkg.sv
`default_nettype none
// ============================================================================
// Module      : top_level_pkg
// Description : Shared constants for the Fibonacci LCD display: HD44780
//               command codes, every cycle count used by the sequencer and
//               the nibble writer, FSM state encodings and small helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package top_level_pkg;

    // HD44780 command bytes
    localparam logic [7:0] c_CMD_FUNC_SET   = 8'h28;  // 4-bit bus, 2 lines, 5x8
    localparam logic [7:0] c_CMD_ENTRY_MODE = 8'h06;  // increment, no shift
    localparam logic [7:0] c_CMD_DISPLAY_ON = 8'h0C;  // display on, no cursor
    localparam logic [7:0] c_CMD_CLEAR      = 8'h01;
    localparam logic [7:0] c_CMD_SET_ADDR0  = 8'h80;  // DDRAM address 0

    // Power-on initialisation nibbles
    localparam logic [3:0] c_INIT_NIB_WAKE  = 4'h3;
    localparam logic [3:0] c_INIT_NIB_4BIT  = 4'h2;

    // Cycle counts (50 MHz clock)
    localparam int c_CYC_SETUP      = 2;
    localparam int c_CYC_E_HIGH     = 12;
    localparam int c_CYC_HOLD       = 2;
    localparam int c_CYC_NIB_GAP    = 50;
    localparam int c_CYC_BYTE_GAP   = 2000;
    localparam int c_CYC_POWER_ON   = 750000;
    localparam int c_CYC_INIT1      = 205000;
    localparam int c_CYC_INIT2      = 5000;
    localparam int c_CYC_INIT3      = 2000;
    localparam int c_CYC_INIT4      = 2000;
    localparam int c_CYC_CLEAR      = 82000;

    // Simulation shortening: long waits collapse to this length
    localparam int c_FAST_THRESHOLD = 2000;
    localparam int c_CYC_FAST       = 64;

    // Wide enough for the 750000-cycle power-on wait
    localparam int c_CNT_W          = 20;

    // Sequencer states
    typedef enum logic [2:0] {
        S_PWR_WAIT  = 3'd0,
        S_INIT_BUSY = 3'd1,
        S_INIT_WAIT = 3'd2,
        S_CMD_BUSY  = 3'd3,
        S_CLR_WAIT  = 3'd4,
        S_ADDR_BUSY = 3'd5,
        S_CHAR_BUSY = 3'd6
    } ctrl_state_t;

    // Nibble writer states
    typedef enum logic [2:0] {
        W_IDLE     = 3'd0,
        W_SETUP    = 3'd1,
        W_HIGH     = 3'd2,
        W_HOLD     = 3'd3,
        W_GAP      = 3'd4,
        W_BYTE_GAP = 3'd5
    } wr_state_t;

    // Terminal counter value for a wait of the given length. Counters run
    // 0..N-1, so the wait lasts exactly N cycles.
    function automatic logic [c_CNT_W-1:0] f_wait_last(input int cycles, input bit fast);
        int eff;
        eff = (fast && (cycles >= c_FAST_THRESHOLD)) ? c_CYC_FAST : cycles;
        return c_CNT_W'(eff - 1);
    endfunction

    // Uppercase ASCII hex digit
    function automatic logic [7:0] f_hex_char(input logic [3:0] digit);
        if (digit < 4'd10) begin
            return 8'h30 + {4'h0, digit};
        end
        return 8'h37 + {4'h0, digit};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_writer
// Description : Sends one byte (high nibble first) or one single nibble to an
//               HD44780 LCD on a 4-bit bus, generating the enable strobe with
//               setup / pulse / hold / gap timing. Pulses o_done once the
//               transfer, including its trailing idle time, is complete.
// Ports       : clk           - clock, rising edge
//               rst_n         - synchronous reset, active low
//               i_start       - one-cycle request, accepted only when idle
//               i_data        - byte to send (bits [3:0] when single nibble)
//               i_rs          - register select for the transfer
//               i_nibble_only - send only i_data[3:0], no trailing byte gap
//               o_sf_d        - LCD data nibble
//               o_lcd_e       - LCD enable strobe
//               o_lcd_rs      - LCD register select
//               o_done        - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_writer #(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_rs,
    input  logic       i_nibble_only,
    output logic [3:0] o_sf_d,
    output logic       o_lcd_e,
    output logic       o_lcd_rs,
    output logic       o_done
);
    import top_level_pkg::*;

    localparam logic [c_CNT_W-1:0] c_LAST_SETUP    = f_wait_last(c_CYC_SETUP,    FAST_SIM);
    localparam logic [c_CNT_W-1:0] c_LAST_E_HIGH   = f_wait_last(c_CYC_E_HIGH,   FAST_SIM);
    localparam logic [c_CNT_W-1:0] c_LAST_HOLD     = f_wait_last(c_CYC_HOLD,     FAST_SIM);
    localparam logic [c_CNT_W-1:0] c_LAST_NIB_GAP  = f_wait_last(c_CYC_NIB_GAP,  FAST_SIM);
    localparam logic [c_CNT_W-1:0] c_LAST_BYTE_GAP = f_wait_last(c_CYC_BYTE_GAP, FAST_SIM);

    wr_state_t          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_low_nib;
    logic               r_nib_only;
    logic               r_last;      // the nibble on the bus is the final one
    logic [3:0]         r_sf_d;
    logic               r_lcd_e;
    logic               r_lcd_rs;
    logic               r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= W_IDLE;
            r_cnt      <= '0;
            r_low_nib  <= 4'h0;
            r_nib_only <= 1'b0;
            r_last     <= 1'b0;
            r_sf_d     <= 4'h0;
            r_lcd_e    <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                W_IDLE: begin
                    if (i_start) begin
                        r_sf_d     <= i_nibble_only ? i_data[3:0] : i_data[7:4];
                        r_low_nib  <= i_data[3:0];
                        r_lcd_rs   <= i_rs;
                        r_nib_only <= i_nibble_only;
                        r_last     <= i_nibble_only;
                        r_cnt      <= '0;
                        r_state    <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    if (r_cnt == c_LAST_SETUP) begin
                        r_cnt   <= '0;
                        r_lcd_e <= 1'b1;
                        r_state <= W_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                W_HIGH: begin
                    if (r_cnt == c_LAST_E_HIGH) begin
                        r_cnt   <= '0;
                        r_lcd_e <= 1'b0;
                        r_state <= W_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                W_HOLD: begin
                    if (r_cnt == c_LAST_HOLD) begin
                        r_cnt <= '0;
                        if (!r_last) begin
                            r_state <= W_GAP;
                        end else if (r_nib_only) begin
                            // Single nibbles leave the trailing wait to the sequencer
                            r_done  <= 1'b1;
                            r_state <= W_IDLE;
                        end else begin
                            r_state <= W_BYTE_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                W_GAP: begin
                    if (r_cnt == c_LAST_NIB_GAP) begin
                        r_cnt   <= '0;
                        r_sf_d  <= r_low_nib;
                        r_last  <= 1'b1;
                        r_state <= W_SETUP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                W_BYTE_GAP: begin
                    if (r_cnt == c_LAST_BYTE_GAP) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= W_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_lcd_e <= 1'b0;
                    r_state <= W_IDLE;
                end
            endcase
        end
    end

    assign o_sf_d   = r_sf_d;
    assign o_lcd_e  = r_lcd_e;
    assign o_lcd_rs = r_lcd_rs;
    assign o_done   = r_done;

endmodule
`default_nettype wire

// File: rtl/top_level.sv
`default_nettype none
// ============================================================================
// Module      : top_level
// Description : Fibonacci counter shown on an HD44780 LCD. Runs the LCD
//               power-on initialisation, then repeatedly writes register A as
//               four hex characters at DDRAM address 0, stepping the 16-bit
//               Fibonacci datapath once after every complete refresh.
// Ports       : CLK_50MHZ - 50 MHz clock, rising edge
//               BTN_NORTH - synchronous reset, active low
//               SF_D      - LCD data nibble
//               LCD_E     - LCD enable strobe
//               LCD_RS    - LCD register select (0 command, 1 data)
//               LCD_RW    - LCD read/write, always write
// Revision    : 1.0 - initial release
// ============================================================================
module top_level #(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic        CLK_50MHZ,
    input  logic        BTN_NORTH,
    output logic [11:8] SF_D,
    output logic        LCD_E,
    output logic        LCD_RS,
    output logic        LCD_RW
);
    import top_level_pkg::*;

    localparam logic [c_CNT_W-1:0] c_LAST_POWER = f_wait_last(c_CYC_POWER_ON, FAST_SIM);
    localparam logic [c_CNT_W-1:0] c_LAST_INIT1 = f_wait_last(c_CYC_INIT1,    FAST_SIM);
    localparam logic [c_CNT_W-1:0] c_LAST_INIT2 = f_wait_last(c_CYC_INIT2,    FAST_SIM);
    localparam logic [c_CNT_W-1:0] c_LAST_INIT3 = f_wait_last(c_CYC_INIT3,    FAST_SIM);
    localparam logic [c_CNT_W-1:0] c_LAST_INIT4 = f_wait_last(c_CYC_INIT4,    FAST_SIM);
    localparam logic [c_CNT_W-1:0] c_LAST_CLEAR = f_wait_last(c_CYC_CLEAR,    FAST_SIM);

    ctrl_state_t        r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_idx;       // init nibble / command / character index
    logic [15:0]        r_a;
    logic [15:0]        r_b;
    logic               r_start;
    logic [7:0]         r_data;
    logic               r_rs;
    logic               r_nib_only;

    logic               w_done;
    logic [3:0]         w_sf_d;
    logic [c_CNT_W-1:0] w_init_wait_last;
    logic [7:0]         w_cmd_next;
    logic [1:0]         w_char_idx;
    logic [3:0]         w_digit;
    logic [7:0]         w_char;

    // Lookups for the item that follows the current index
    always_comb begin
        w_init_wait_last = c_LAST_INIT1;
        case (r_idx)
            2'd0:    w_init_wait_last = c_LAST_INIT1;
            2'd1:    w_init_wait_last = c_LAST_INIT2;
            2'd2:    w_init_wait_last = c_LAST_INIT3;
            default: w_init_wait_last = c_LAST_INIT4;
        endcase

        w_cmd_next = c_CMD_ENTRY_MODE;
        case (r_idx)
            2'd0:    w_cmd_next = c_CMD_ENTRY_MODE;
            2'd1:    w_cmd_next = c_CMD_DISPLAY_ON;
            default: w_cmd_next = c_CMD_CLEAR;
        endcase

        // After the address command the first (most significant) digit goes out
        w_char_idx = (r_state == S_CHAR_BUSY) ? (r_idx + 2'd1) : 2'd0;
        w_digit    = r_a[15:12];
        case (w_char_idx)
            2'd0:    w_digit = r_a[15:12];
            2'd1:    w_digit = r_a[11:8];
            2'd2:    w_digit = r_a[7:4];
            default: w_digit = r_a[3:0];
        endcase
        w_char = f_hex_char(w_digit);
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (!BTN_NORTH) begin
            r_state    <= S_PWR_WAIT;
            r_cnt      <= '0;
            r_idx      <= 2'd0;
            r_a        <= 16'h0000;
            r_b        <= 16'h0001;
            r_start    <= 1'b0;
            r_data     <= 8'h00;
            r_rs       <= 1'b0;
            r_nib_only <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_PWR_WAIT: begin
                    if (r_cnt == c_LAST_POWER) begin
                        r_cnt      <= '0;
                        r_idx      <= 2'd0;
                        r_start    <= 1'b1;
                        r_data     <= {4'h0, c_INIT_NIB_WAKE};
                        r_rs       <= 1'b0;
                        r_nib_only <= 1'b1;
                        r_state    <= S_INIT_BUSY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_INIT_BUSY: begin
                    if (w_done) begin
                        r_cnt   <= '0;
                        r_state <= S_INIT_WAIT;
                    end
                end
                S_INIT_WAIT: begin
                    if (r_cnt == w_init_wait_last) begin
                        r_cnt   <= '0;
                        r_start <= 1'b1;
                        r_rs    <= 1'b0;
                        if (r_idx == 2'd3) begin
                            r_idx      <= 2'd0;
                            r_data     <= c_CMD_FUNC_SET;
                            r_nib_only <= 1'b0;
                            r_state    <= S_CMD_BUSY;
                        end else begin
                            r_idx      <= r_idx + 2'd1;
                            r_data     <= {4'h0, (r_idx == 2'd2) ? c_INIT_NIB_4BIT : c_INIT_NIB_WAKE};
                            r_nib_only <= 1'b1;
                            r_state    <= S_INIT_BUSY;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CMD_BUSY: begin
                    if (w_done) begin
                        if (r_idx == 2'd3) begin
                            r_cnt   <= '0;
                            r_state <= S_CLR_WAIT;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_start <= 1'b1;
                            r_data  <= w_cmd_next;
                            r_rs    <= 1'b0;
                        end
                    end
                end
                S_CLR_WAIT: begin
                    if (r_cnt == c_LAST_CLEAR) begin
                        r_cnt   <= '0;
                        r_start <= 1'b1;
                        r_data  <= c_CMD_SET_ADDR0;
                        r_rs    <= 1'b0;
                        r_state <= S_ADDR_BUSY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ADDR_BUSY: begin
                    if (w_done) begin
                        r_idx   <= 2'd0;
                        r_start <= 1'b1;
                        r_data  <= w_char;
                        r_rs    <= 1'b1;
                        r_state <= S_CHAR_BUSY;
                    end
                end
                S_CHAR_BUSY: begin
                    if (w_done) begin
                        r_start <= 1'b1;
                        if (r_idx == 2'd3) begin
                            // Refresh complete: one Fibonacci step, then re-address
                            r_a     <= r_b;
                            r_b     <= r_a + r_b;
                            r_data  <= c_CMD_SET_ADDR0;
                            r_rs    <= 1'b0;
                            r_state <= S_ADDR_BUSY;
                        end else begin
                            r_idx  <= r_idx + 2'd1;
                            r_data <= w_char;
                            r_rs   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_PWR_WAIT;
                end
            endcase
        end
    end

    lcd_writer #(
        .FAST_SIM(FAST_SIM)
    ) u_lcd_writer (
        .clk           (CLK_50MHZ),
        .rst_n         (BTN_NORTH),
        .i_start       (r_start),
        .i_data        (r_data),
        .i_rs          (r_rs),
        .i_nibble_only (r_nib_only),
        .o_sf_d        (w_sf_d),
        .o_lcd_e       (LCD_E),
        .o_lcd_rs      (LCD_RS),
        .o_done        (w_done)
    );

    assign SF_D   = w_sf_d;
    assign LCD_RW = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_top_level.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_top_level
// Description : Self-checking bench for top_level (FAST_SIM=1). A monitor
//               decodes the LCD bus into nibbles/bytes; scenario tasks push
//               expected transfers into a queue and compare them in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_level;

    logic        clk = 1'b0;
    logic        btn = 1'b0;
    logic [11:8] sf_d;
    logic        lcd_e;
    logic        lcd_rs;
    logic        lcd_rw;

    always #10 clk = ~clk;

    top_level #(
        .FAST_SIM(1'b1)
    ) dut (
        .CLK_50MHZ (clk),
        .BTN_NORTH (btn),
        .SF_D      (sf_d),
        .LCD_E     (lcd_e),
        .LCD_RS    (lcd_rs),
        .LCD_RW    (lcd_rw)
    );

    int checks = 0;
    int errors = 0;

    // {rs, byte}; single init nibbles appear as {0, 4'h0, nibble}
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];

    // Monitor statistics
    int rw_bad    = 0;
    int setup_bad = 0;
    int width_bad = 0;
    int rs_split  = 0;
    int pulses    = 0;

    function automatic logic [7:0] hex_ch(input logic [3:0] d);
        if (d < 4'd10) return 8'h30 + {4'h0, d};
        return 8'h41 + {4'h0, d} - 8'd10;
    endfunction

    // Bus monitor, sampled on the falling edge
    initial begin : monitor
        logic       prev_e;
        logic [4:0] hist1, hist2;
        logic       have_high, high_rs;
        logic [3:0] high_nib;
        int         nib_count, width;
        prev_e = 1'b0; hist1 = '0; hist2 = '0;
        have_high = 1'b0; high_rs = 1'b0; high_nib = 4'h0;
        nib_count = 0; width = 0;
        forever begin
            @(negedge clk);
            if (lcd_rw !== 1'b0) rw_bad++;
            if (btn !== 1'b1) begin
                prev_e    = 1'b0;
                nib_count = 0;
                have_high = 1'b0;
                width     = 0;
            end else begin
                if (lcd_e === 1'b1 && prev_e === 1'b0) begin
                    if (hist1 !== {lcd_rs, sf_d} || hist2 !== {lcd_rs, sf_d}) setup_bad++;
                    width = 1;
                    if (nib_count < 4) begin
                        obs_q.push_back({lcd_rs, 4'h0, sf_d});
                    end else if (!have_high) begin
                        have_high = 1'b1;
                        high_rs   = lcd_rs;
                        high_nib  = sf_d;
                    end else begin
                        if (high_rs !== lcd_rs) rs_split++;
                        obs_q.push_back({high_rs, high_nib, sf_d});
                        have_high = 1'b0;
                    end
                    nib_count++;
                end else if (lcd_e === 1'b1) begin
                    width++;
                end else if (prev_e === 1'b1) begin
                    pulses++;
                    if (width != 12) width_bad++;
                end
                prev_e = lcd_e;
            end
            hist2 = hist1;
            hist1 = {lcd_rs, sf_d};
        end
    end

    task automatic push_init_expect();
        exp_q.push_back(9'h003);
        exp_q.push_back(9'h003);
        exp_q.push_back(9'h003);
        exp_q.push_back(9'h002);
        exp_q.push_back(9'h028);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
    endtask

    task automatic push_refresh_expect(input logic [15:0] a);
        exp_q.push_back(9'h080);
        exp_q.push_back({1'b1, hex_ch(a[15:12])});
        exp_q.push_back({1'b1, hex_ch(a[11:8])});
        exp_q.push_back({1'b1, hex_ch(a[7:4])});
        exp_q.push_back({1'b1, hex_ch(a[3:0])});
    endtask

    task automatic test_reset();
        btn = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({sf_d, lcd_e, lcd_rs, lcd_rw} !== 7'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got SF_D=%h E=%b RS=%b RW=%b, expected all 0",
                         i, sf_d, lcd_e, lcd_rs, lcd_rw);
            end
        end
    endtask

    task automatic test_first_pulse();
        int n, w;
        btn = 1'b1;
        @(posedge clk); #1;              // first running edge: cycle 0
        n = 0;
        while (lcd_e !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n != 66) begin
            errors++;
            $display("FAIL first_rise_delay: got %0d cycles, expected 66", n);
        end
        checks++;
        if (sf_d !== 4'h3 || lcd_rs !== 1'b0) begin
            errors++;
            $display("FAIL first_nibble: got SF_D=%h RS=%b, expected SF_D=3 RS=0", sf_d, lcd_rs);
        end
        w = 0;
        while (lcd_e === 1'b1 && w < 300) begin
            @(posedge clk); #1; w++;
        end
        checks++;
        if (w != 12) begin
            errors++;
            $display("FAIL first_pulse_width: got %0d cycles, expected 12", w);
        end
    endtask

    task automatic test_init();
        logic [8:0] got, want;
        int t, item;
        push_init_expect();
        push_refresh_expect(16'h0000);
        push_refresh_expect(16'h0001);
        item = 0;
        while (exp_q.size() > 0) begin
            t = 0;
            while (obs_q.size() == 0 && t < 4000) begin @(posedge clk); #1; t++; end
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL init_stream item %0d: got no transfer in %0d cycles, expected %h", item, t, exp_q[0]);
                exp_q.delete();
            end else begin
                got  = obs_q.pop_front();
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL init_stream item %0d: got %h, expected %h", item, got, want);
                end
            end
            item++;
        end
    endtask

    task automatic test_refresh();
        logic [15:0] a, b, s;
        logic [8:0]  got, want;
        int t;
        a = 16'h0001; b = 16'h0002;      // state after the two refreshes already seen
        for (int r = 0; r < 26; r++) begin
            push_refresh_expect(a);
            while (exp_q.size() > 0) begin
                t = 0;
                while (obs_q.size() == 0 && t < 4000) begin @(posedge clk); #1; t++; end
                checks++;
                if (obs_q.size() == 0) begin
                    errors++;
                    $display("FAIL refresh %0d: got no transfer in %0d cycles, expected %h", r + 2, t, exp_q[0]);
                    exp_q.delete();
                end else begin
                    got  = obs_q.pop_front();
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL refresh %0d (A=%h): got %h, expected %h", r + 2, a, got, want);
                    end
                end
            end
            s = a + b;
            a = b;
            b = s;
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] got, want;
        int t, item;
        t = 0;
        while (!(lcd_e === 1'b1 && lcd_rs === 1'b1) && t < 4000) begin @(posedge clk); #1; t++; end
        checks++;
        if (t >= 4000) begin
            errors++;
            $display("FAIL reset_mid_wait: got no data nibble in %0d cycles, expected one", t);
        end
        btn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (lcd_e !== 1'b0 || sf_d !== 4'h0 || lcd_rs !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort: got E=%b SF_D=%h RS=%b, expected E=0 SF_D=0 RS=0", lcd_e, sf_d, lcd_rs);
        end
        btn = 1'b1;
        obs_q.delete();
        exp_q.delete();
        push_init_expect();
        push_refresh_expect(16'h0000);
        item = 0;
        while (exp_q.size() > 0) begin
            t = 0;
            while (obs_q.size() == 0 && t < 4000) begin @(posedge clk); #1; t++; end
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL replay_stream item %0d: got no transfer in %0d cycles, expected %h", item, t, exp_q[0]);
                exp_q.delete();
            end else begin
                got  = obs_q.pop_front();
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL replay_stream item %0d: got %h, expected %h", item, got, want);
                end
            end
            item++;
        end
    endtask

    task automatic test_bus_rules();
        checks++;
        if (rw_bad != 0) begin
            errors++;
            $display("FAIL lcd_rw_low: got %0d cycles with RW!=0, expected 0", rw_bad);
        end
        checks++;
        if (setup_bad != 0) begin
            errors++;
            $display("FAIL nibble_setup: got %0d rises without 2-cycle setup, expected 0", setup_bad);
        end
        checks++;
        if (width_bad != 0 || pulses < 100) begin
            errors++;
            $display("FAIL pulse_width: got %0d bad widths over %0d pulses, expected 0 bad and >=100 pulses",
                     width_bad, pulses);
        end
        checks++;
        if (rs_split != 0) begin
            errors++;
            $display("FAIL byte_rs_consistent: got %0d bytes with mixed RS, expected 0", rs_split);
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_first_pulse();
        test_init();
        test_refresh();
        test_reset_mid();
        test_bus_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
